// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   - Request size encodings (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD)
//   - FSM state type for the load/store sequencer
//   - Lane geometry constants used by the lane align/merge logic
package lsu_pkg;

    // req_size encodings
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    // Lane geometry: 32-bit little-endian word made of four byte lanes
    localparam int unsigned WORD_W = 32;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned HALF_W = 16;
    localparam int unsigned LANES  = WORD_W / BYTE_W;

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StCapture,
        StWrite,
        StResp
    } lsu_state_e;

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering for the load/store unit.
//   Load path : selects the byte/half/word addressed by offset_i out of rword_i and
//               sign- or zero-extends it onto ldata_o.
//   Store path: overwrites the addressed lane of rword_i with the low bits of wdata_i
//               and presents the merged word on mword_o (word stores pass wdata_i).
// Ports:
//   rword_i    word read from memory
//   offset_i   byte address bits [1:0]
//   size_i     access size (SZ_BYTE / SZ_HALF / SZ_WORD)
//   unsigned_i 1 = zero-extend loads, 0 = sign-extend
//   wdata_i    right-justified store data
//   ldata_o    extended load result
//   mword_o    merged store word
// Half accesses use offset_i[1] only and word accesses ignore offset_i, so any
// misalignment that reaches this block is silently forced aligned.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [WORD_W-1:0] rword_i,
    input  logic [1:0]        offset_i,
    input  logic [1:0]        size_i,
    input  logic              unsigned_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic [WORD_W-1:0] ldata_o,
    output logic [WORD_W-1:0] mword_o
);

    logic [BYTE_W-1:0] byte_sel;
    logic [HALF_W-1:0] half_sel;
    logic [4:0]        byte_lsb;
    logic [4:0]        half_lsb;

    always_comb begin
        byte_lsb = {offset_i, 3'b000};
        half_lsb = {offset_i[1], 4'b0000};
        byte_sel = rword_i[byte_lsb +: BYTE_W];
        half_sel = rword_i[half_lsb +: HALF_W];
        ldata_o  = rword_i;
        mword_o  = wdata_i;
        case (size_i)
            SZ_BYTE: begin
                ldata_o = {{(WORD_W - BYTE_W){byte_sel[BYTE_W-1] & ~unsigned_i}}, byte_sel};
                mword_o = rword_i;
                mword_o[byte_lsb +: BYTE_W] = wdata_i[BYTE_W-1:0];
            end
            SZ_HALF: begin
                ldata_o = {{(WORD_W - HALF_W){half_sel[HALF_W-1] & ~unsigned_i}}, half_sel};
                mword_o = rword_i;
                mword_o[half_lsb +: HALF_W] = wdata_i[HALF_W-1:0];
            end
            default: begin
                ldata_o = rword_i;
                mword_o = wdata_i;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store front-end between the multicycle datapath and the word-addressed,
// edge-triggered data memory.
// Ports:
//   clk, rst                    clock, asynchronous active-low reset
//   req_valid/req_ready         request handshake (ready only in IDLE)
//   req_write, req_size,
//   req_unsigned, req_addr,
//   req_wdata                   request payload, latched on acceptance
//   resp_valid/resp_rdata/
//   resp_error                  one-cycle completion pulse with load data / error flag
//   mem_address, mem_writedata,
//   mem_read, mem_write         memory interface (all registered)
//   mem_readdata                memory read data, sampled at the end of CAPTURE
// Sequences (cycles after the acceptance edge):
//   load          READ -> CAPTURE -> RESP
//   word store    WRITE -> RESP
//   sub-word store READ -> CAPTURE -> WRITE -> RESP  (read-modify-write)
//   error         RESP
// Build option: define LSU_MISALIGN_TRAP_EN to reject misaligned half/word accesses
// through the error path; otherwise they are forced aligned.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned DEPTH_LOG2 = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [DATA_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_error,
    output logic [DATA_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_readdata
);

    lsu_state_e        state;
    logic [1:0]        offset_q;
    logic [1:0]        size_q;
    logic              unsigned_q;
    logic              write_q;
    logic [DATA_W-1:0] wdata_q;

    logic              req_bad;
    logic [DATA_W-1:0] word_index;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] merge_word;
    logic              unused_addr;

    // Address bits above the memory depth wrap and are dropped
    assign word_index  = {{(DATA_W - DEPTH_LOG2){1'b0}}, req_addr[DEPTH_LOG2+1:2]};
    assign unused_addr = ^req_addr[DATA_W-1:DEPTH_LOG2+2];

    always_comb begin
`ifdef LSU_MISALIGN_TRAP_EN
        req_bad = (req_size == SZ_RSVD)
                || ((req_size == SZ_HALF) && req_addr[0])
                || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
        req_bad = (req_size == SZ_RSVD);
`endif
    end

    lsu_lane_align u_lane_align (
        .rword_i    (mem_readdata),
        .offset_i   (offset_q),
        .size_i     (size_q),
        .unsigned_i (unsigned_q),
        .wdata_i    (wdata_q),
        .ldata_o    (load_data),
        .mword_o    (merge_word)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= StIdle;
            offset_q      <= 2'b00;
            size_q        <= SZ_BYTE;
            unsigned_q    <= 1'b0;
            write_q       <= 1'b0;
            wdata_q       <= '0;
            req_ready     <= 1'b1;
            resp_valid    <= 1'b0;
            resp_rdata    <= '0;
            resp_error    <= 1'b0;
            mem_address   <= '0;
            mem_writedata <= '0;
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (req_valid) begin
                        offset_q   <= req_addr[1:0];
                        size_q     <= req_size;
                        unsigned_q <= req_unsigned;
                        write_q    <= req_write;
                        wdata_q    <= req_wdata;
                        req_ready  <= 1'b0;
                        if (req_bad) begin
                            resp_valid <= 1'b1;
                            resp_error <= 1'b1;
                            resp_rdata <= '0;
                            state      <= StResp;
                        end else begin
                            mem_address <= word_index;
                            if (req_write && (req_size == SZ_WORD)) begin
                                mem_writedata <= req_wdata;
                                mem_write     <= 1'b1;
                                state         <= StWrite;
                            end else begin
                                // Loads and sub-word stores both start with a read
                                mem_read <= 1'b1;
                                state    <= StRead;
                            end
                        end
                    end
                end
                StRead: begin
                    mem_read <= 1'b0;
                    state    <= StCapture;
                end
                StCapture: begin
                    if (write_q) begin
                        mem_writedata <= merge_word;
                        mem_write     <= 1'b1;
                        state         <= StWrite;
                    end else begin
                        resp_rdata <= load_data;
                        resp_valid <= 1'b1;
                        state      <= StResp;
                    end
                end
                StWrite: begin
                    mem_write  <= 1'b0;
                    resp_rdata <= '0;
                    resp_valid <= 1'b1;
                    state      <= StResp;
                end
                StResp: begin
                    resp_valid <= 1'b0;
                    resp_error <= 1'b0;
                    resp_rdata <= '0;
                    req_ready  <= 1'b1;
                    state      <= StIdle;
                end
                default: begin
                    state     <= StIdle;
                    req_ready <= 1'b1;
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural edge-triggered memory.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [31:0] mem_address;
    logic [31:0] mem_writedata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_readdata = '0;

    logic [31:0] mem [0:1023];

    int checks = 0;
    int errors = 0;

    // Per-cycle samples of the last request, index = cycles after acceptance
    logic        rd_s    [1:5];
    logic        wr_s    [1:5];
    logic [31:0] addr_s  [1:5];
    logic [31:0] wd_s    [1:5];
    logic        rv_s    [1:5];
    logic [31:0] rdata_s [1:5];
    logic        err_s   [1:5];

    always #5 clk = ~clk;

    load_store_unit #(.DATA_W(32), .DEPTH_LOG2(10)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_write     (req_write),
        .req_size      (req_size),
        .req_unsigned  (req_unsigned),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_rdata    (resp_rdata),
        .resp_error    (resp_error),
        .mem_address   (mem_address),
        .mem_writedata (mem_writedata),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_readdata  (mem_readdata)
    );

    // Edge-triggered memory: acts on the rising edge of each strobe
    always @(posedge mem_read) begin
        #1;
        mem_readdata = mem[mem_address[9:0]];
    end

    always @(posedge mem_write) begin
        #1;
        mem[mem_address[9:0]] = mem_writedata;
    end

    task automatic run_req(input logic w, input logic [1:0] sz, input logic u,
                           input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_before_req: got %b want 1", req_ready);
        end
        req_valid = 1'b1;
        req_write = w;
        req_size = sz;
        req_unsigned = u;
        req_addr = a;
        req_wdata = d;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            rd_s[c] = mem_read;
            wr_s[c] = mem_write;
            addr_s[c] = mem_address;
            wd_s[c] = mem_writedata;
            rv_s[c] = resp_valid;
            rdata_s[c] = resp_rdata;
            err_s[c] = resp_error;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({req_ready, resp_valid, resp_error, mem_read, mem_write} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 10000",
                     {req_ready, resp_valid, resp_error, mem_read, mem_write});
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({mem_address, mem_writedata, resp_rdata} !== 96'h0) begin
            errors++;
            $display("FAIL reset_data: got %h %h %h want 0 0 0",
                     mem_address, mem_writedata, resp_rdata);
        end
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: ready %b valid %b want 1 0", req_ready, resp_valid);
        end
    endtask

    task automatic test_store_word();
        run_req(1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF);
        checks++;
        if ({wr_s[1], rd_s[1], wr_s[2]} !== 3'b100) begin
            errors++;
            $display("FAIL sw_strobe: got wr1 %b rd1 %b wr2 %b want 1 0 0", wr_s[1], rd_s[1], wr_s[2]);
        end
        checks++;
        if (addr_s[1] !== 32'd4 || wd_s[1] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL sw_addr_data: got %h %h want 00000004 deadbeef", addr_s[1], wd_s[1]);
        end
        checks++;
        if ({rv_s[1], rv_s[2], err_s[2], rv_s[3]} !== 4'b0100) begin
            errors++;
            $display("FAIL sw_resp: got %b want 0100", {rv_s[1], rv_s[2], err_s[2], rv_s[3]});
        end
        checks++;
        if (mem[4] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL sw_mem: got %h want deadbeef", mem[4]);
        end
    endtask

    task automatic test_loads();
        run_req(1'b0, SZ_BYTE, 1'b0, 32'h13, 32'h0);
        checks++;
        if ({rd_s[1], rd_s[2], wr_s[1], wr_s[2]} !== 4'b1000) begin
            errors++;
            $display("FAIL lb_strobe: got %b want 1000", {rd_s[1], rd_s[2], wr_s[1], wr_s[2]});
        end
        checks++;
        if (rv_s[2] !== 1'b0 || rv_s[3] !== 1'b1 || rdata_s[3] !== 32'hFFFFFFDE) begin
            errors++;
            $display("FAIL lb_signed: got v2 %b v3 %b %h want 0 1 ffffffde",
                     rv_s[2], rv_s[3], rdata_s[3]);
        end
        run_req(1'b0, SZ_BYTE, 1'b1, 32'h13, 32'h0);
        checks++;
        if (rv_s[3] !== 1'b1 || rdata_s[3] !== 32'h000000DE) begin
            errors++;
            $display("FAIL lbu: got %b %h want 1 000000de", rv_s[3], rdata_s[3]);
        end
        run_req(1'b0, SZ_HALF, 1'b0, 32'h10, 32'h0);
        checks++;
        if (rdata_s[3] !== 32'hFFFFBEEF) begin
            errors++;
            $display("FAIL lh_signed: got %h want ffffbeef", rdata_s[3]);
        end
        run_req(1'b0, SZ_HALF, 1'b1, 32'h12, 32'h0);
        checks++;
        if (rdata_s[3] !== 32'h0000DEAD) begin
            errors++;
            $display("FAIL lhu_upper: got %h want 0000dead", rdata_s[3]);
        end
        // 0x1010 wraps onto word 4 in a 1024-word memory
        run_req(1'b0, SZ_WORD, 1'b0, 32'h1010, 32'h0);
        checks++;
        if (addr_s[1] !== 32'd4 || rdata_s[3] !== 32'hDEADBEEF || err_s[3] !== 1'b0) begin
            errors++;
            $display("FAIL lw_wrap: got addr %h data %h err %b want 00000004 deadbeef 0",
                     addr_s[1], rdata_s[3], err_s[3]);
        end
    endtask

    task automatic test_subword_store();
        run_req(1'b1, SZ_BYTE, 1'b0, 32'h11, 32'h00000055);
        checks++;
        if ({rd_s[1], wr_s[1], rd_s[2], wr_s[2], rd_s[3], wr_s[3], wr_s[4]} !== 7'b1000010) begin
            errors++;
            $display("FAIL sb_strobe: got %b want 1000010",
                     {rd_s[1], wr_s[1], rd_s[2], wr_s[2], rd_s[3], wr_s[3], wr_s[4]});
        end
        checks++;
        if (wd_s[3] !== 32'hDEAD55EF) begin
            errors++;
            $display("FAIL sb_merge: got %h want dead55ef", wd_s[3]);
        end
        checks++;
        if ({rv_s[3], rv_s[4], err_s[4], rv_s[5]} !== 4'b0100 || rdata_s[4] !== 32'h0) begin
            errors++;
            $display("FAIL sb_resp: got %b %h want 0100 00000000",
                     {rv_s[3], rv_s[4], err_s[4], rv_s[5]}, rdata_s[4]);
        end
        run_req(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0);
        checks++;
        if (rdata_s[3] !== 32'hDEAD55EF) begin
            errors++;
            $display("FAIL sb_readback: got %h want dead55ef", rdata_s[3]);
        end
        run_req(1'b1, SZ_HALF, 1'b0, 32'h12, 32'hAAAA1234);
        checks++;
        if (wr_s[3] !== 1'b1 || wd_s[3] !== 32'h123455EF || mem[4] !== 32'h123455EF) begin
            errors++;
            $display("FAIL sh_merge: got wr %b data %h mem %h want 1 123455ef 123455ef",
                     wr_s[3], wd_s[3], mem[4]);
        end
    endtask

    task automatic test_error();
        run_req(1'b0, SZ_RSVD, 1'b0, 32'h10, 32'h0);
        checks++;
        if ({rv_s[1], err_s[1], rv_s[2], err_s[2]} !== 4'b1100 || rdata_s[1] !== 32'h0) begin
            errors++;
            $display("FAIL rsvd_resp: got %b %h want 1100 00000000",
                     {rv_s[1], err_s[1], rv_s[2], err_s[2]}, rdata_s[1]);
        end
        checks++;
        if ({rd_s[1], rd_s[2], rd_s[3], wr_s[1], wr_s[2], wr_s[3]} !== 6'b0) begin
            errors++;
            $display("FAIL rsvd_strobe: got %b want 000000",
                     {rd_s[1], rd_s[2], rd_s[3], wr_s[1], wr_s[2], wr_s[3]});
        end
    endtask

    task automatic test_misalign();
        run_req(1'b0, SZ_HALF, 1'b0, 32'h11, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
        checks++;
        if ({rv_s[1], err_s[1], rd_s[1], wr_s[1], rd_s[2]} !== 5'b11000) begin
            errors++;
            $display("FAIL lh_misalign_trap: got %b want 11000",
                     {rv_s[1], err_s[1], rd_s[1], wr_s[1], rd_s[2]});
        end
`else
        checks++;
        if (rv_s[3] !== 1'b1 || err_s[3] !== 1'b0 || rdata_s[3] !== 32'h000055EF) begin
            errors++;
            $display("FAIL lh_misalign_forced: got %b %b %h want 1 0 000055ef",
                     rv_s[3], err_s[3], rdata_s[3]);
        end
`endif
    endtask

    task automatic test_back_to_back();
        int   n_acc = 0;
        int   n_wr = 0;
        int   rv_c = -1;
        int   acc_c[2] = '{0, 0};
        int   wr_c[2] = '{0, 0};
        logic acc;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_size = SZ_WORD;
        req_unsigned = 1'b0;
        req_addr = 32'h20;
        req_wdata = 32'h11111111;
        for (int c = 0; c < 12; c++) begin
            if (mem_write) begin
                if (n_wr < 2) wr_c[n_wr] = c;
                n_wr++;
            end
            if (resp_valid && rv_c < 0) rv_c = c;
            acc = req_valid & req_ready;
            if (acc) begin
                if (n_acc < 2) acc_c[n_acc] = c;
                n_acc++;
            end
            @(posedge clk);
            #1;
            if (acc) begin
                if (n_acc == 1) begin
                    req_addr = 32'h24;
                    req_wdata = 32'h22222222;
                end else begin
                    req_valid = 1'b0;
                end
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        checks++;
        if (n_acc != 2 || acc_c[1] - acc_c[0] != 3) begin
            errors++;
            $display("FAIL b2b_accept: got %0d accepts gap %0d want 2 gap 3",
                     n_acc, acc_c[1] - acc_c[0]);
        end
        checks++;
        if (n_wr != 2 || wr_c[1] - wr_c[0] != 3) begin
            errors++;
            $display("FAIL b2b_write_gap: got %0d pulses gap %0d want 2 gap 3",
                     n_wr, wr_c[1] - wr_c[0]);
        end
        checks++;
        if (rv_c != acc_c[0] + 2) begin
            errors++;
            $display("FAIL b2b_first_resp: got cycle %0d want %0d", rv_c, acc_c[0] + 2);
        end
        checks++;
        if (mem[8] !== 32'h11111111 || mem[9] !== 32'h22222222) begin
            errors++;
            $display("FAIL b2b_mem: got %h %h want 11111111 22222222", mem[8], mem[9]);
        end
    endtask

    task automatic test_reset_mid();
        logic seen;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_size = SZ_HALF;
        req_unsigned = 1'b0;
        req_addr = 32'h10;
        req_wdata = 32'h0000CAFE;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        // Now in CAPTURE
        rst = 1'b0;
        #1;
        checks++;
        if ({mem_read, mem_write, resp_valid, req_ready} !== 4'b0001 || mem_address !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid_outputs: got %b addr %h want 0001 00000000",
                     {mem_read, mem_write, resp_valid, req_ready}, mem_address);
        end
        seen = 1'b0;
        repeat (2) begin
            @(negedge clk);
            seen = seen | mem_write | resp_valid;
        end
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            seen = seen | mem_write | resp_valid;
        end
        checks++;
        if (seen !== 1'b0 || mem[4] !== 32'h123455EF) begin
            errors++;
            $display("FAIL rst_mid_mem: got activity %b mem %h want 0 123455ef", seen, mem[4]);
        end
        run_req(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0);
        checks++;
        if (rv_s[3] !== 1'b1 || rdata_s[3] !== 32'h123455EF) begin
            errors++;
            $display("FAIL rst_mid_recover: got %b %h want 1 123455ef", rv_s[3], rdata_s[3]);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        test_reset();
        test_store_word();
        test_loads();
        test_subword_store();
        test_error();
        test_misalign();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Strobe exclusivity holds at every sample point
    always @(negedge clk) begin
        if (rst && mem_read && mem_write) begin
            checks++;
            errors++;
            $display("FAIL strobe_exclusive: got read %b write %b want not both", mem_read, mem_write);
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule
